pcileech_tlp128_axis_tx: RTL
============================

// Module: pcileech_tlp128_axis_tx
//
// PURPOSE
// - Sink end of the IfTlp128 packed-TLP bus; transmitter onto the 64-bit IfPCIeTlpRxTx AXI-stream toward the PCIe core TX.
// - Pulls one packed TLP (up to 18 dual-dwords: 4 DW header + 32 DW data) from an IfTlp128 source.
// - Serialises the TLP into 64-bit beats with keep/last, under valid/ready backpressure.
// - Sits between the TLP packers (shadow cfg responder, FIFO TLP path) and the PCIe core TX port.
//
// PARAMETERS
// - MAX_BEATS    18   dual-dwords per packed TLP; beat index range is 0..MAX_BEATS-1.
// - WAIT_TIMEOUT 15   cycles to wait for tlp.valid after tlp.req_data before aborting the fetch.
//
// PORTS
// - clk            in   1     single clock; all logic is in this domain.
// - rst_n          in   1     reset, asynchronous assert, active-low.
// - tlp.data       in   1188  packed TLP. Beat i = data[66*i +: 66]: [63:0] = DW pair, [64] = last, [65] = keep DW2.
// - tlp.valid      in   1     tlp.data is valid this cycle.
// - tlp.has_data   in   1     source holds at least one TLP.
// - tlp.req_data   out  1     one-cycle pop request to the source.
// - tx.data        out  64    AXIS beat data.
// - tx.keep        out  8     byte enables.
// - tx.last        out  1     final beat of the TLP.
// - tx.valid       out  1     beat valid.
// - tx.ready       in   1     core accepts the beat.
// - stat_tlp_cnt   out  16    count of TLPs fully transmitted; wraps 0xFFFF->0.
// - stat_err       out  1     one-cycle pulse on timeout or forced-last overrun.
//
// BEHAVIOUR
// - Reset (rst_n=0, async):
//   - tlp.req_data, tx.valid, tx.last, stat_err = 0; tx.data, tx.keep, stat_tlp_cnt = 0.
//   - State returns to IDLE and any buffered TLP is discarded, including a reset that lands mid-TLP.
// - FSM IDLE:
//   - If tlp.has_data=1, assert tlp.req_data for exactly one cycle and go to WAIT.
// - FSM WAIT:
//   - Timeout counter runs from 0.
//   - On tlp.valid=1, latch all 1188 bits into buf, set beat=0, go to SEND.
//   - If the counter reaches WAIT_TIMEOUT with no tlp.valid, pulse stat_err and go to IDLE.
//   - A tlp.valid arriving in any state other than WAIT is ignored.
// - FSM SEND:
//   - Beat output fields:
//     - tx.data = buf beat[63:0].
//     - tx.last = beat[64] OR (beat == MAX_BEATS-1).
//     - tx.keep = (tx.last AND NOT beat[65]) ? 8'h0F : 8'hFF.
//   - tx.valid=1 throughout SEND.
//   - Outputs are registered and held stable while tx.ready=0; AXIS rules apply, with no valid drop before the handshake.
//   - On tx.valid & tx.ready with tx.last=0: beat++ and the next beat is presented the following cycle, giving one beat per clock at full ready.
//   - On tx.valid & tx.ready with tx.last=1: stat_tlp_cnt++ and go to IDLE.
//     - If the forced last fired (beat == MAX_BEATS-1 with beat[64]=0), also pulse stat_err.
// - Latency: tlp.req_data to first tx.valid = 1 + (valid delay) + 1 cycles, i.e. 3 cycles when the source answers in 1.
// - Gap between TLPs without the prefetch option: IDLE -> req -> WAIT -> SEND adds at least 3 idle cycles.
//
// CONFIGURATION
// - Macro PCILEECH_TLP128_TX_PREFETCH_EN.
// - Defined: a second 1188-bit buffer is added.
//   - During SEND, if buffer 2 is empty and tlp.has_data=1, the block issues tlp.req_data and captures into buffer 2 (same WAIT_TIMEOUT rule).
//   - On the last-beat handshake, if buffer 2 is full, it becomes current and the next TLP's beat 0 is presented the next cycle with tx.valid continuously high.
//   - Reset clears both buffers.
// - Undefined: single buffer; tlp.req_data is only ever issued from IDLE.
//
// TESTING
// - 3DW MRd, beat0 last=0, beat1 last=1 keep2=0, tx.ready=1:
//   - exactly two beats; beat1 keep=8'h0F, last=1; stat_tlp_cnt=1.
// - 4DW MWr with 32 DW payload, last only on beat 17, tx.ready toggling 1/0:
//   - 18 beats; data stable across every ready=0 cycle; keep=8'hFF on all beats.
// - Malformed TLP with no last bit set:
//   - beat 17 carries last=1 (forced); stat_err pulses on its handshake.
// - req_data issued but source never asserts valid:
//   - stat_err pulses at cycle 15 after req; FSM back in IDLE; no tx.valid.
// - rst_n pulled low during beat 5 of an 18-beat TLP:
//   - tx.valid=0 immediately; after release, a new has_data starts cleanly from beat 0.
// - With PCILEECH_TLP128_TX_PREFETCH_EN, two queued 2-beat TLPs, tx.ready=1:
//   - 4 consecutive valid beats with no gap; stat_tlp_cnt=2.

Source files
------------

// File: rtl/pcileech_tlp128_axis_tx_if.sv
// Bus bundles around the packed-TLP transmitter: the IfTlp128 source side and the 64-bit AXIS TX side.
// master = driver of the payload, slave = consumer.
interface pcileech_tlp128_if;
    logic [1187:0] data;
    logic          valid;
    logic          has_data;
    logic          req_data;

    modport master (output data, output valid, output has_data, input  req_data);
    modport slave  (input  data, input  valid, input  has_data, output req_data);
endinterface

interface pcileech_axis64_if;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        valid;
    logic        ready;

    modport master (output data, output keep, output last, output valid, input  ready);
    modport slave  (input  data, input  keep, input  last, input  valid, output ready);
endinterface

// File: rtl/pcileech_tlp128_axis_tx.sv
// Pulls one packed TLP (up to 18 dual-dwords) from an IfTlp128 source and streams it as 64-bit AXIS beats.
// Define PCILEECH_TLP128_TX_PREFETCH_EN to fetch the next TLP into a second buffer while sending.
//
// state  | meaning
// S_IDLE | no TLP held; pop the source when it has data
// S_WAIT | pop issued; down-counter guards the wait for tlp.valid
// S_SEND | buffer held; beats presented on tx with registered outputs
module pcileech_tlp128_axis_tx #(
    parameter int MAX_BEATS    = 18,
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    pcileech_tlp128_if.slave  tlp,
    pcileech_axis64_if.master tx,
    output logic [15:0]       stat_tlp_cnt,
    output logic              stat_err
);
    localparam int BUF_W  = 66 * MAX_BEATS;
    localparam int BEAT_W = $clog2(MAX_BEATS);
    localparam int OFF_W  = $clog2(BUF_W);
    localparam int CNT_W  = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(MAX_BEATS - 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        forced;
    } beat_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               err_q, err_d;
    logic [15:0]        tlp_cnt_q, tlp_cnt_d;
    beat_t              out_q, out_d;
    logic               tx_valid_q, tx_valid_d;
`ifdef PCILEECH_TLP128_TX_PREFETCH_EN
    logic [BUF_W-1:0]   buf2_q, buf2_d;
    logic               buf2_full_q, buf2_full_d;
    logic               pf_wait_q, pf_wait_d;
`endif

    // A beat index of MAX_BEATS-1 ends the TLP even without its last flag (forced last).
    function automatic beat_t present(input logic [BUF_W-1:0] b, input logic [BEAT_W-1:0] idx);
        logic [OFF_W-1:0] off;
        logic [65:0]      raw;
        beat_t            o;
        off      = OFF_W'(idx) * OFF_W'(66);
        raw      = b[off +: 66];
        o.data   = raw[63:0];
        o.forced = !raw[64] && (idx == LAST_IDX);
        o.last   = raw[64] || (idx == LAST_IDX);
        o.keep   = (o.last && !raw[65]) ? 8'h0F : 8'hFF;
        return o;
    endfunction

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        req_d      = 1'b0;
        err_d      = 1'b0;
        tlp_cnt_d  = tlp_cnt_q;
        out_d      = out_q;
        tx_valid_d = tx_valid_q;
`ifdef PCILEECH_TLP128_TX_PREFETCH_EN
        buf2_d      = buf2_q;
        buf2_full_d = buf2_full_q;
        pf_wait_d   = pf_wait_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                tx_valid_d = 1'b0;
                if (tlp.has_data) begin
                    req_d   = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tlp.valid) begin
                    buf_d   = tlp.data;
                    beat_d  = '0;
                    state_d = S_SEND;
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SEND: begin
`ifdef PCILEECH_TLP128_TX_PREFETCH_EN
                if (pf_wait_q) begin
                    if (tlp.valid) begin
                        buf2_d      = tlp.data;
                        buf2_full_d = 1'b1;
                        pf_wait_d   = 1'b0;
                    end else if (cnt_q == '0) begin
                        err_d     = 1'b1;
                        pf_wait_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else if (!buf2_full_q && tlp.has_data && !req_q) begin
                    req_d     = 1'b1;
                    pf_wait_d = 1'b1;
                    cnt_d     = CNT_LOAD;
                end
`endif
                if (!tx_valid_q) begin
                    out_d      = present(buf_q, beat_q);
                    tx_valid_d = 1'b1;
                end else if (tx.ready) begin
                    if (!out_q.last) begin
                        beat_d = beat_q + 1'b1;
                        out_d  = present(buf_q, beat_q + 1'b1);
                    end else begin
                        tlp_cnt_d  = tlp_cnt_q + 16'd1;
                        err_d      = err_d | out_q.forced;
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
`ifdef PCILEECH_TLP128_TX_PREFETCH_EN
                        // Back-to-back: the next TLP comes from buffer 2 or straight off the bus this cycle.
                        if (buf2_full_q) begin
                            buf_d       = buf2_q;
                            buf2_full_d = 1'b0;
                            beat_d      = '0;
                            out_d       = present(buf2_q, '0);
                            tx_valid_d  = 1'b1;
                            state_d     = S_SEND;
                        end else if (pf_wait_q && tlp.valid) begin
                            buf_d       = tlp.data;
                            buf2_full_d = 1'b0;
                            beat_d      = '0;
                            out_d       = present(tlp.data, '0);
                            tx_valid_d  = 1'b1;
                            state_d     = S_SEND;
                        end else if (pf_wait_q && cnt_q != '0) begin
                            pf_wait_d = 1'b0;
                            state_d   = S_WAIT;
                        end
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            beat_q     <= '0;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            err_q      <= 1'b0;
            tlp_cnt_q  <= '0;
            out_q      <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            err_q      <= err_d;
            tlp_cnt_q  <= tlp_cnt_d;
            out_q      <= out_d;
            tx_valid_q <= tx_valid_d;
        end
    end

`ifdef PCILEECH_TLP128_TX_PREFETCH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf2_q      <= '0;
            buf2_full_q <= 1'b0;
            pf_wait_q   <= 1'b0;
        end else begin
            buf2_q      <= buf2_d;
            buf2_full_q <= buf2_full_d;
            pf_wait_q   <= pf_wait_d;
        end
    end
`endif

    assign tlp.req_data = req_q;
    assign tx.data      = out_q.data;
    assign tx.keep      = out_q.keep;
    assign tx.last      = out_q.last;
    assign tx.valid     = tx_valid_q;
    assign stat_tlp_cnt = tlp_cnt_q;
    assign stat_err     = err_q;
endmodule
